// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan-code to ASCII decoder with an output FIFO.
// Parses make, break and E0-extended sequences, tracks Shift and Caps Lock,
// and queues printable characters behind a valid/ready handshake.
// Optional build macro TYPEMATIC_FILTER_EN suppresses auto-repeat of held keys.
module ps2_ascii_decoder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scan_valid,
  input  logic [7:0]       scan_code,
  output logic             ascii_valid,
  input  logic             ascii_ready,
  output logic [7:0]       ascii_data,
  output logic [CNT_W-1:0] level,
  output logic             overflow,
  output logic             caps_on
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StExt    = 2'd1;
  localparam logic [1:0] StBrk    = 2'd2;
  localparam logic [1:0] StExtBrk = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          lshift_q, rshift_q, caps_q, caps_held_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] level_q;
  logic          overflow_q;

  logic       make_ev, brk_ev;
  logic       tr_hit, tr_letter;
  logic [7:0] tr_char;
  logic       suppress;
  logic       push_req, push, pop, full;

  // Prefix parser; extended sequences are swallowed without side effects.
  always_comb begin
    state_d = state_q;
    if (scan_valid) begin
      case (state_q)
        StIdle: begin
          if (scan_code == 8'hE0)      state_d = StExt;
          else if (scan_code == 8'hF0) state_d = StBrk;
          else                         state_d = StIdle;
        end
        StExt:   state_d = (scan_code == 8'hF0) ? StExtBrk : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  assign make_ev = scan_valid && (state_q == StIdle) &&
                   (scan_code != 8'hE0) && (scan_code != 8'hF0);
  assign brk_ev  = scan_valid && (state_q == StBrk);

  // Parser state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Shift and Caps Lock tracking; caps_held stops a held Caps key from re-toggling.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
    end else if (make_ev) begin
      if (scan_code == 8'h12) lshift_q <= 1'b1;
      if (scan_code == 8'h59) rshift_q <= 1'b1;
      if (scan_code == 8'h58 && !caps_held_q) begin
        caps_q      <= ~caps_q;
        caps_held_q <= 1'b1;
      end
    end else if (brk_ev) begin
      if (scan_code == 8'h12) lshift_q    <= 1'b0;
      if (scan_code == 8'h59) rshift_q    <= 1'b0;
      if (scan_code == 8'h58) caps_held_q <= 1'b0;
    end
  end

  // Scan-code to ASCII table; letters are looked up lowercase and folded afterwards.
  always_comb begin
    tr_hit    = 1'b1;
    tr_letter = 1'b0;
    tr_char   = 8'h00;
    case (scan_code)
      8'h45: tr_char = 8'h30;
      8'h16: tr_char = 8'h31;
      8'h1E: tr_char = 8'h32;
      8'h26: tr_char = 8'h33;
      8'h25: tr_char = 8'h34;
      8'h2E: tr_char = 8'h35;
      8'h36: tr_char = 8'h36;
      8'h3D: tr_char = 8'h37;
      8'h3E: tr_char = 8'h38;
      8'h46: tr_char = 8'h39;
      8'h29: tr_char = 8'h20;
      8'h5A: tr_char = 8'h0D;
      8'h66: tr_char = 8'h08;
      8'h1C: begin tr_char = 8'h61; tr_letter = 1'b1; end
      8'h32: begin tr_char = 8'h62; tr_letter = 1'b1; end
      8'h21: begin tr_char = 8'h63; tr_letter = 1'b1; end
      8'h23: begin tr_char = 8'h64; tr_letter = 1'b1; end
      8'h24: begin tr_char = 8'h65; tr_letter = 1'b1; end
      8'h2B: begin tr_char = 8'h66; tr_letter = 1'b1; end
      8'h34: begin tr_char = 8'h67; tr_letter = 1'b1; end
      8'h33: begin tr_char = 8'h68; tr_letter = 1'b1; end
      8'h43: begin tr_char = 8'h69; tr_letter = 1'b1; end
      8'h3B: begin tr_char = 8'h6A; tr_letter = 1'b1; end
      8'h42: begin tr_char = 8'h6B; tr_letter = 1'b1; end
      8'h4B: begin tr_char = 8'h6C; tr_letter = 1'b1; end
      8'h3A: begin tr_char = 8'h6D; tr_letter = 1'b1; end
      8'h31: begin tr_char = 8'h6E; tr_letter = 1'b1; end
      8'h44: begin tr_char = 8'h6F; tr_letter = 1'b1; end
      8'h4D: begin tr_char = 8'h70; tr_letter = 1'b1; end
      8'h15: begin tr_char = 8'h71; tr_letter = 1'b1; end
      8'h2D: begin tr_char = 8'h72; tr_letter = 1'b1; end
      8'h1B: begin tr_char = 8'h73; tr_letter = 1'b1; end
      8'h2C: begin tr_char = 8'h74; tr_letter = 1'b1; end
      8'h3C: begin tr_char = 8'h75; tr_letter = 1'b1; end
      8'h2A: begin tr_char = 8'h76; tr_letter = 1'b1; end
      8'h1D: begin tr_char = 8'h77; tr_letter = 1'b1; end
      8'h22: begin tr_char = 8'h78; tr_letter = 1'b1; end
      8'h35: begin tr_char = 8'h79; tr_letter = 1'b1; end
      8'h1A: begin tr_char = 8'h7A; tr_letter = 1'b1; end
      default: tr_hit = 1'b0;
    endcase
    if (tr_letter && ((lshift_q | rshift_q) ^ caps_q)) tr_char = tr_char - 8'h20;
  end

`ifdef TYPEMATIC_FILTER_EN
  logic [7:0] last_make_q;
  logic       last_make_vld_q;

  assign suppress = last_make_vld_q && (last_make_q == scan_code);

  // Remember the last plain make so typematic repeats of a held key are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_make_q     <= 8'h00;
      last_make_vld_q <= 1'b0;
    end else if (make_ev) begin
      last_make_q     <= scan_code;
      last_make_vld_q <= 1'b1;
    end else if (brk_ev && scan_code == last_make_q) begin
      last_make_vld_q <= 1'b0;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign full     = (level_q == CNT_W'(FIFO_DEPTH));
  assign pop      = (level_q != '0) && ascii_ready;
  assign push_req = make_ev && tr_hit && !suppress;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req && (!full || pop);

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      level_q <= level_q + CNT_W'(1);
      else if (pop && !push) level_q <= level_q - CNT_W'(1);
      if (push_req && !push) overflow_q <= 1'b1;
    end
  end

  // FIFO storage; contents are qualified by level so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tr_char;
  end

  assign ascii_valid = (level_q != '0);
  assign ascii_data  = ascii_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign caps_on     = caps_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed self-checking bench for ps2_ascii_decoder (default FIFO_DEPTH = 8).
module tb_ps2_ascii_decoder;

  logic       clk;
  logic       rst_n;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       ascii_valid;
  logic       ascii_ready;
  logic [7:0] ascii_data;
  logic [3:0] level;
  logic       overflow;
  logic       caps_on;

  int checks;
  int failures;

  ps2_ascii_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_valid  (scan_valid),
    .scan_code   (scan_code),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .ascii_data  (ascii_data),
    .level       (level),
    .overflow    (overflow),
    .caps_on     (caps_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte for one clock; called and returns on a falling edge.
  task automatic send(input logic [7:0] b);
    scan_valid = 1'b1;
    scan_code  = b;
    @(negedge clk);
    scan_valid = 1'b0;
    scan_code  = 8'h00;
  endtask

  // Check the head entry, then accept it for one clock.
  task automatic pop_expect(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, {7'd0, ascii_valid}, 8'h01);
    chk({tag, "_data"}, ascii_data, exp);
    ascii_ready = 1'b1;
    @(negedge clk);
    ascii_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] burst [9];
    logic [7:0] exp_chars [8];
    int         n_rep;
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    scan_valid  = 1'b0;
    scan_code   = 8'h00;
    ascii_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_valid", {7'd0, ascii_valid}, 8'h00);
    chk("rst_level", {4'd0, level}, 8'h00);
    chk("rst_overflow", {7'd0, overflow}, 8'h00);
    chk("rst_data", ascii_data, 8'h00);
    chk("rst_caps", {7'd0, caps_on}, 8'h00);

    // Single key with consumer always ready; no bypass on empty push
    ascii_ready = 1'b1;
    send(8'h1C);
    chk("t1_valid", {7'd0, ascii_valid}, 8'h01);
    chk("t1_data", ascii_data, 8'h61);
    chk("t1_level1", {4'd0, level}, 8'h01);
    send(8'hF0);
    send(8'h1C);
    chk("t1_level0", {4'd0, level}, 8'h00);
    chk("t1_ovf", {7'd0, overflow}, 8'h00);
    ascii_ready = 1'b0;

    // Shift on letters and digits
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12);
    send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'h12); send(8'h16); send(8'hF0); send(8'h16);
    send(8'hF0); send(8'h12);
    chk("t2_level", {4'd0, level}, 8'h03);
    pop_expect("t2_A", 8'h41);
    pop_expect("t2_a", 8'h61);
    pop_expect("t2_1", 8'h31);

    // Caps Lock, held Caps does not re-toggle, shift XOR caps
    send(8'h58);
    chk("t3_caps_on", {7'd0, caps_on}, 8'h01);
    send(8'h58);
    chk("t3_caps_held", {7'd0, caps_on}, 8'h01);
    send(8'hF0); send(8'h58);
    send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12);
    chk("t3_level", {4'd0, level}, 8'h02);
    pop_expect("t3_A", 8'h41);
    pop_expect("t3_a", 8'h61);
    send(8'h58); send(8'hF0); send(8'h58);
    chk("t3_caps_off", {7'd0, caps_on}, 8'h00);

    // Extended keys ignored, back-to-back prefixes, special and unmapped codes
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h1C);
    send(8'h29); send(8'hF0); send(8'h29);
    send(8'hE0); send(8'hE0); send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'hF0); send(8'h16); send(8'hF0); send(8'h16);
    send(8'h5A); send(8'hF0); send(8'h5A);
    send(8'h66); send(8'hF0); send(8'h66);
    send(8'h76); send(8'hF0); send(8'h76);
    chk("t4_level", {4'd0, level}, 8'h05);
    pop_expect("t4_space", 8'h20);
    pop_expect("t4_ee_a", 8'h61);
    pop_expect("t4_ff_1", 8'h31);
    pop_expect("t4_enter", 8'h0D);
    pop_expect("t4_bksp", 8'h08);
    chk("t4_empty", {7'd0, ascii_valid}, 8'h00);

    // Overflow: nine letters into an eight-deep FIFO
    burst = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    for (int i = 0; i < 9; i++) begin
      send(burst[i]); send(8'hF0); send(burst[i]);
    end
    chk("t5_level_full", {4'd0, level}, 8'h08);
    chk("t5_ovf", {7'd0, overflow}, 8'h01);
    chk("t5_head", ascii_data, 8'h61);
    // Push while full with a concurrent pop is accepted
    ascii_ready = 1'b1;
    send(8'h42);
    ascii_ready = 1'b0;
    send(8'hF0); send(8'h42);
    chk("t5_level_kept", {4'd0, level}, 8'h08);
    exp_chars = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h6B};
    for (int i = 0; i < 8; i++) pop_expect($sformatf("t5_pop%0d", i), exp_chars[i]);
    chk("t5_level0", {4'd0, level}, 8'h00);
    chk("t5_ovf_sticky", {7'd0, overflow}, 8'h01);

    // Typematic repeats of a held key
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'h1C); send(8'hF0); send(8'h1C);
`ifdef TYPEMATIC_FILTER_EN
    n_rep = 2;
`else
    n_rep = 4;
`endif
    chk("t6_level", {4'd0, level}, 8'(n_rep));
    for (int i = 0; i < n_rep; i++) pop_expect($sformatf("t6_pop%0d", i), 8'h61);

    // Reset mid-sequence discards the pending break prefix and clears state
    send(8'h58);
    send(8'hF0);
    do_reset();
    chk("t7_caps", {7'd0, caps_on}, 8'h00);
    chk("t7_ovf", {7'd0, overflow}, 8'h00);
    send(8'h1C);
    chk("t7_level", {4'd0, level}, 8'h01);
    pop_expect("t7_a", 8'h61);
    send(8'h58);
    chk("t7_caps_again", {7'd0, caps_on}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_ascii_decoder.md
Name: ps2_ascii_decoder

Overview:
- Sequential successor to the combinational keycode-to-ASCII table.
- Consumes a byte stream of PS/2 set-2 scan codes from the PS/2 receiver, one byte per `scan_valid` pulse.
- Tracks make/break (F0), extended (E0), Shift and Caps Lock state, and translates make events of printable keys to ASCII.
- Buffers the ASCII characters in a parametrised FIFO with a valid/ready output handshake toward the CPU-side keyboard device.

Parameters:
- FIFO_DEPTH, 8, number of ASCII entries buffered; power of two, at least 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the `level` output; derived, do not override.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- scan_valid  input  1  `scan_code` is valid this cycle; one byte consumed per high cycle.
- scan_code  input  8  PS/2 set-2 scan byte.
- ascii_valid  output  1  FIFO non-empty; `ascii_data` is valid.
- ascii_ready  input  1  consumer accepts the head entry when `ascii_valid` is also high.
- ascii_data  output  8  FIFO head character.
- level  output  CNT_W  current FIFO occupancy, 0..FIFO_DEPTH.
- overflow  output  1  sticky; a character was dropped because the FIFO was full.
- caps_on  output  1  current Caps Lock state, for the keyboard LED.

Behaviour:
- Reset (rst_n low at a rising edge):
  - parser goes to IDLE; both shift flags, `caps_on` and `caps_held` clear; FIFO empties.
  - `ascii_valid`=0, `level`=0, `overflow`=0, `ascii_data`=8'h00.
  - Reset mid-sequence (e.g. after F0) discards the partial sequence.
- Parser FSM advances only on cycles where `scan_valid`=1. States and transitions:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte is a make of that code, return to IDLE.
  - EXT: F0 -> EXT_BRK; any other byte is an extended make, ignored, -> IDLE.
  - BRK: any byte is a break of that code, -> IDLE.
  - EXT_BRK: any byte is an extended break, ignored, -> IDLE.
  - Back-to-back prefixes (E0 E0, F0 F0): the second prefix byte is treated as a plain code per the rules above; no lock-up.
- Modifiers (non-extended only):
  - Make 12 sets lshift; make 59 sets rshift. Break 12 clears lshift; break 59 clears rshift.
  - shift = lshift | rshift.
  - Make 58 with `caps_held`=0 toggles `caps_on` and sets `caps_held`. Make 58 with `caps_held`=1 does nothing. Break 58 clears `caps_held`.
  - Modifier keys never push to the FIFO.
- Translation (non-extended makes only):
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 -> 30..39.
  - Letters, set-2 map: 1C=a 32=b 21=c 23=d 24=e 2B=f 34=g 33=h 43=i 3B=j 42=k 4B=l 3A=m 31=n 44=o 4D=p 15=q 2D=r 1B=s 2C=t 3C=u 2A=v 1D=w 22=x 35=y 1A=z. Output 61..7A when (shift XOR caps_on)=0, otherwise 41..5A.
  - Digits are unaffected by shift or caps.
  - 29 -> 20 (space), 5A -> 0D (enter), 66 -> 08 (backspace).
  - Unmapped codes and all breaks: no push.
- Latency: the final byte of a make accepted in cycle N is pushed at the end of N; `ascii_valid` is high in N+1 if the FIFO was empty.
- FIFO:
  - Push of a translated make when not full: write the entry, `level`+1.
  - Push when full: the character is dropped and `overflow` is set. Exception: if a pop occurs in the same cycle, the push is accepted and `level` is unchanged.
  - Pop when `ascii_valid` & `ascii_ready`: `level`-1.
  - Simultaneous push and pop when not empty: `level` unchanged, data order preserved.
  - Push into an empty FIFO with `ascii_ready`=1 in the same cycle: no bypass; the character appears next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - `ascii_data` holds the head entry while `ascii_valid`=1; it is don't-care when empty.
  - `overflow` clears only on reset.

Optional Feature:
- Macro: TYPEMATIC_FILTER_EN.
- Defined:
  - A `last_make` register (8 bits plus valid bit) records the last non-extended make code.
  - A make equal to `last_make` with no intervening break of that code is suppressed: no push.
  - A break of `last_make` clears its valid bit; any different make replaces it.
  - Reset clears it.
- Undefined: every translated make pushes, so held keys auto-repeat into the FIFO.

Test Plan:
- Bytes 1C, F0 1C with `ascii_ready`=1 -> exactly one character 61; `level` returns to 0; `overflow`=0.
- 12, 1C, F0 12, 1C -> characters 41 then 61; digit 16 sent with 12 held -> 31.
- 58, F0 58, 1C -> `caps_on`=1, character 41; then 12, 1C -> 61 (shift XOR caps); second 58/F0 58 -> `caps_on`=0.
- E0 75, E0 F0 75, then 29 -> only 20 pushed; an arrow-key code is never emitted; parser back in IDLE.
- `ascii_ready`=0, send FIFO_DEPTH+1 letter makes -> `level`=8, `overflow`=1, first 8 characters popped in order, the 9th lost; a full-FIFO push with a concurrent pop is accepted.
- With TYPEMATIC_FILTER_EN: 1C,1C,1C, F0 1C, 1C -> two 61 characters; without the macro -> four.
